// File: rtl/reg_writeback_queue.sv
// Register-file write-back queue: merges ALU and memory results into an in-order
// FIFO, drains one write per cycle, and forwards pending values to decode.
module reg_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_reg,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_reg,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    RegWrite,
  output logic [4:0]              WriteReg,
  output logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [4:0]              Read1,
  input  logic [4:0]              Read2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic [DATA_WIDTH-1:0]   fwd1_data,
  output logic [DATA_WIDTH-1:0]   fwd2_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [4:0]            reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  ptr_t                  rd_ptr;
  ptr_t                  wr_ptr;
  ptr_t                  mem_slot;
  logic                  alu_fire;
  logic                  mem_fire;
  logic                  alu_push;
  logic                  mem_push;
  logic                  pop;

  // Readiness looks only at the registered count; a same-cycle pop earns no credit.
  assign alu_ready = (count < CW'(DEPTH));
  assign mem_ready = (count < CW'(DEPTH - 1)) || ((count < CW'(DEPTH)) && !alu_valid);

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;
  // Writes to r0 are architecturally void: handshake completes, nothing is stored.
  assign alu_push = alu_fire && (alu_reg != 5'd0);
  assign mem_push = mem_fire && (mem_reg != 5'd0);
  assign pop      = (count != '0);
  assign mem_slot = wr_ptr + ptr_t'(alu_push);

  assign empty = (count == '0) && !RegWrite;

  // NOTE: storage carries no reset; validity is tracked by count, so clearing
  // the array would only cost reset fan-out without changing behaviour.
  always_ff @(posedge clock) begin
    if (alu_push) begin
      reg_q[wr_ptr]  <= alu_reg;
      data_q[wr_ptr] <= alu_data;
    end
    if (mem_push) begin
      reg_q[mem_slot]  <= mem_reg;
      data_q[mem_slot] <= mem_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      count    <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
      wr_ptr   <= wr_ptr + ptr_t'(alu_push) + ptr_t'(mem_push);
      RegWrite <= pop;
      if (pop) begin
        WriteReg  <= reg_q[rd_ptr];
        WriteData <= data_q[rd_ptr];
        rd_ptr    <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides earlier ones.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    ptr_t idx;
    idx       = rd_ptr;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    if (RegWrite && (WriteReg == Read1) && (Read1 != 5'd0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = WriteData;
    end
    if (RegWrite && (WriteReg == Read2) && (Read2 != 5'd0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = WriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + ptr_t'(i);
      if ((CW'(i) < count) && (reg_q[idx] == Read1) && (Read1 != 5'd0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_q[idx];
      end
      if ((CW'(i) < count) && (reg_q[idx] == Read2) && (Read2 != 5'd0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct {
    logic [4:0]    r;
    logic [DW-1:0] d;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]    alu_reg, mem_reg, WriteReg, Read1, Read2;
  logic [DW-1:0] alu_data, mem_data, WriteData, fwd1_data, fwd2_data;
  logic          RegWrite, fwd1_hit, fwd2_hit, empty;
  logic [2:0]    count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  entry_t        q[$];
  logic          m_rw = 1'b0;
  logic [4:0]    m_wreg = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          a_done, m_done;

  always #5 clock = ~clock;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .Read1(Read1), .Read2(Read2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .empty(empty), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  function automatic logic model_alu_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic model_mem_ready(input logic av);
    return (q.size() < DEPTH - 1) || ((q.size() < DEPTH) && !av);
  endfunction

  // Youngest pending value for r: queue back beats queue front beats output stage.
  task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r == 5'd0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == r) begin
        hit = 1'b1;
        d   = q[i].d;
        return;
      end
    end
    if (m_rw && m_wreg == r) begin
      hit = 1'b1;
      d   = m_wdata;
    end
  endtask

  task automatic compare_all();
    logic          h;
    logic [DW-1:0] d;
    check("alu_ready", alu_ready, model_alu_ready());
    check("mem_ready", mem_ready, model_mem_ready(alu_valid));
    check("RegWrite", RegWrite, m_rw);
    check("WriteReg", WriteReg, m_wreg);
    check("WriteData", WriteData, m_wdata);
    check("count", count, q.size());
    check("empty", empty, (q.size() == 0) && !m_rw);
    model_fwd(Read1, h, d);
    check("fwd1_hit", fwd1_hit, h);
    check("fwd1_data", fwd1_data, d);
    model_fwd(Read2, h, d);
    check("fwd2_hit", fwd2_hit, h);
    check("fwd2_data", fwd2_data, d);
  endtask

  task automatic model_edge();
    logic   af, mf;
    entry_t e;
    af = 1'b0;
    mf = 1'b0;
    if (!reset_n) begin
      q.delete();
      m_rw    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      af = alu_valid && model_alu_ready();
      mf = mem_valid && model_mem_ready(alu_valid);
      if (q.size() > 0) begin
        e       = q.pop_front();
        m_rw    = 1'b1;
        m_wreg  = e.r;
        m_wdata = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (af && alu_reg != 5'd0) q.push_back('{r: alu_reg, d: alu_data});
      if (mf && mem_reg != 5'd0) q.push_back('{r: mem_reg, d: mem_data});
    end
    a_done = af;
    m_done = mf;
  endtask

  // One cycle: inputs are already applied; check mid-cycle, then advance the model.
  task automatic step();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [DW-1:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  initial begin
    reset_n = 1'b0;
    Read1 = '0;
    Read2 = '0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single ALU result, then idle drain
    drive(1'b1, 5'd5, 32'hAA, 1'b0, '0, '0);
    Read1 = 5'd5;
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) step();

    // Same destination from both ports: mem result is younger
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    Read1 = 5'd3;
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) step();

    // Back-to-back ALU stream with no stall
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1), 32'h100 + i, 1'b0, '0, '0);
      Read2 = 5'(i);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) step();

    // r0 write is swallowed
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
    Read1 = 5'd0;
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) step();

    // Build up occupancy with dual pushes, then reset mid-drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(2 * i + 8), 32'hA0 + i, 1'b1, 5'(2 * i + 9), 32'hB0 + i);
      Read1 = 5'(2 * i + 8);
      Read2 = 5'(2 * i + 9);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();

    // Randomized traffic; producers hold requests until accepted
    a_done = 1'b1;
    m_done = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (!alu_valid || a_done) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_reg   = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_valid || m_done) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_reg   = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      Read1   = 5'($urandom_range(0, 7));
      Read2   = 5'($urandom_range(0, 7));
      reset_n = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
